// File: rtl/call_arb_pkg.sv
// Shared definitions for the call arbiter: FSM state encoding and defaults.
package call_arb_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Index width that stays at least one bit wide so a single-caller
    // build still has a legal (always zero) index bus.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/call_arbiter_rr_pick.sv
// Round-robin picker: first set request bit strictly after the last-served
// index, wrapping around. Pure combinational.
module rr_pick
    import call_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    int             start_pos;
    int             pick_pos;
    int             sum_pos;

    // Rotate the doubled request vector so the search origin lands at bit 0,
    // priority-encode the lowest set bit, then map back modulo N.
    always_comb begin
        start_pos = (int'(last) >= N - 1) ? 0 : int'(last) + 1;
        doubled   = {req, req};
        rotated   = N'(doubled >> start_pos);
        any       = |req;
        pick_pos  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                pick_pos = k;
            end
        end
        sum_pos = start_pos + pick_pos;
        if (sum_pos >= N) begin
            sum_pos = sum_pos - N;
        end
        winner = IDX_W'(sum_pos);
    end

endmodule

// File: rtl/call_arbiter.sv
// Shares one callee (start/done/result, operands a/b) among several callers.
// Grants round-robin, drives a one-cycle start, waits out the callee's stale
// done flag, then returns the result to the winner with a one-cycle pulse.
module call_arbiter
    import call_arb_pkg::*;
#(
    parameter int NUM_CALLERS = 4,
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int IDX_W       = idx_width(NUM_CALLERS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CALLERS-1:0]       req_valid,
    input  logic [NUM_CALLERS*WIDTH-1:0] req_a,
    input  logic [NUM_CALLERS*WIDTH-1:0] req_b,
    output logic [NUM_CALLERS-1:0]       rsp_done,
    output logic [WIDTH-1:0]             rsp_result,
    output logic                         callee_start,
    output logic [WIDTH-1:0]             callee_a,
    output logic [WIDTH-1:0]             callee_b,
    input  logic [WIDTH-1:0]             callee_result,
    input  logic                         callee_done,
    output logic                         busy,
    output logic [IDX_W-1:0]             grant_idx
);

    state_e                 state_q, state_d;
    logic                   callee_start_q, callee_start_d;
    logic [WIDTH-1:0]       callee_a_q, callee_a_d;
    logic [WIDTH-1:0]       callee_b_q, callee_b_d;
    logic [NUM_CALLERS-1:0] rsp_done_q, rsp_done_d;
    logic [WIDTH-1:0]       rsp_result_q, rsp_result_d;
    logic                   busy_q, busy_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]       last_q, last_d;

    logic [WIDTH-1:0]       op_a [NUM_CALLERS];
    logic [WIDTH-1:0]       op_b [NUM_CALLERS];
    logic                   pick_any;
    logic [IDX_W-1:0]       pick_winner;

    // Unpack the flat operand buses into per-caller words.
    generate
        for (genvar gi = 0; gi < NUM_CALLERS; gi++) begin : g_unpack
            assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
            assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .N     (NUM_CALLERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_valid),
        .last   (last_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    // State and output registers; the last-served pointer resets to the top
    // index so caller 0 is first in line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            callee_start_q <= 1'b0;
            callee_a_q     <= '0;
            callee_b_q     <= '0;
            rsp_done_q     <= '0;
            rsp_result_q   <= '0;
            busy_q         <= 1'b0;
            grant_idx_q    <= '0;
            last_q         <= IDX_W'(NUM_CALLERS - 1);
        end else begin
            state_q        <= state_d;
            callee_start_q <= callee_start_d;
            callee_a_q     <= callee_a_d;
            callee_b_q     <= callee_b_d;
            rsp_done_q     <= rsp_done_d;
            rsp_result_q   <= rsp_result_d;
            busy_q         <= busy_d;
            grant_idx_q    <= grant_idx_d;
            last_q         <= last_d;
        end
    end

    // Next-state logic: GUARD always takes one cycle so the callee's done
    // flag from the previous call is never mistaken for completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_any) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_GUARD;
            ST_GUARD: state_d = ST_WAIT;
            ST_WAIT:  if (callee_done) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; everything holds unless a state changes it,
    // which keeps the callee operands stable for the whole call.
    always_comb begin
        callee_start_d = callee_start_q;
        callee_a_d     = callee_a_q;
        callee_b_d     = callee_b_q;
        rsp_done_d     = rsp_done_q;
        rsp_result_d   = rsp_result_q;
        busy_d         = busy_q;
        grant_idx_d    = grant_idx_q;
        last_d         = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    callee_a_d     = op_a[pick_winner];
                    callee_b_d     = op_b[pick_winner];
                    grant_idx_d    = pick_winner;
                    busy_d         = 1'b1;
                    callee_start_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                callee_start_d = 1'b0;
            end
            ST_WAIT: begin
                if (callee_done) begin
                    rsp_result_d             = callee_result;
                    rsp_done_d               = '0;
                    rsp_done_d[grant_idx_q]  = 1'b1;
                end
            end
            ST_RESP: begin
                rsp_done_d = '0;
                last_d     = grant_idx_q;
                busy_d     = 1'b0;
            end
            default: begin
                callee_start_d = 1'b0;
            end
        endcase
    end

    assign callee_start = callee_start_q;
    assign callee_a     = callee_a_q;
    assign callee_b     = callee_b_q;
    assign rsp_done     = rsp_done_q;
    assign rsp_result   = rsp_result_q;
    assign busy         = busy_q;
    assign grant_idx    = grant_idx_q;

endmodule

// File: tb/tb_call_arbiter.sv
// Bench for call_arbiter: directed scenarios plus a randomized run checked
// against a round-robin reference model. The callee is an adder whose done
// flag drops one cycle after it sees start and rises callee_lat cycles later.
module tb_call_arbiter;

    localparam int NC = 4;
    localparam int W  = 32;

    logic            clk;
    logic            reset;
    logic [NC-1:0]   req_valid;
    logic [NC*W-1:0] req_a;
    logic [NC*W-1:0] req_b;
    logic [NC-1:0]   rsp_done;
    logic [W-1:0]    rsp_result;
    logic            callee_start;
    logic [W-1:0]    callee_a;
    logic [W-1:0]    callee_b;
    logic [W-1:0]    callee_result;
    logic            callee_done;
    logic            busy;
    logic [1:0]      grant_idx;

    int checks = 0;
    int errors = 0;
    int callee_lat = 3;
    int cnt_q;
    logic [W-1:0] res_pend;
    int start_cnt = 0;
    logic [W-1:0] start_a;

    call_arbiter #(.NUM_CALLERS(NC), .WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_done      (rsp_done),
        .rsp_result    (rsp_result),
        .callee_start  (callee_start),
        .callee_a      (callee_a),
        .callee_b      (callee_b),
        .callee_result (callee_result),
        .callee_done   (callee_done),
        .busy          (busy),
        .grant_idx     (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Callee model: registered done stays stale for one cycle after start.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            callee_done   <= 1'b1;
            callee_result <= '0;
            cnt_q         <= 0;
            res_pend      <= '0;
        end else if (callee_start) begin
            cnt_q    <= callee_lat + 1;
            res_pend <= callee_a + callee_b;
        end else if (cnt_q > 1) begin
            callee_done <= 1'b0;
            cnt_q       <= cnt_q - 1;
        end else if (cnt_q == 1) begin
            callee_done   <= 1'b1;
            callee_result <= res_pend;
            cnt_q         <= 0;
        end
    end

    // Record every start pulse and the operand it carried.
    always @(posedge clk) begin
        if (callee_start) begin
            start_cnt <= start_cnt + 1;
            start_a   <= callee_a;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int rr_expect(input logic [NC-1:0] p, input int last);
        for (int k = 1; k <= NC; k++) begin
            int c;
            c = (last + k) % NC;
            if (p[c]) return c;
        end
        return -1;
    endfunction

    task automatic wait_rsp(input int budget, output logic [NC-1:0] d,
                            output int n_start, output int n_done, output bit to);
        d = '0; n_start = -1; n_done = -1; to = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (callee_start === 1'b1 && n_start < 0) n_start = i;
            if (rsp_done !== '0) begin
                d = rsp_done; n_done = i; to = 1'b0;
                return;
            end
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        repeat (2) @(negedge clk);
        checks++; if (rsp_done !== '0) begin errors++; $display("FAIL reset_rsp_done got %b want 0", rsp_done); end
        checks++; if (rsp_result !== '0) begin errors++; $display("FAIL reset_rsp_result got %0d want 0", rsp_result); end
        checks++; if (callee_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", callee_start); end
        checks++; if (callee_a !== '0 || callee_b !== '0) begin errors++; $display("FAIL reset_operands got %0d/%0d want 0/0", callee_a, callee_b); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_idx); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || callee_start !== 1'b0) begin errors++; $display("FAIL idle_no_req got busy=%b start=%b want 0/0", busy, callee_start); end
        $display("test_reset done");
    endtask

    task automatic test_single_call();
        logic [NC-1:0] d; int ns, nd; bit to; int s0;
        s0 = start_cnt;
        callee_lat = 3;
        req_a[2*W +: W] = 32'd7; req_b[2*W +: W] = 32'd5;
        req_valid = 4'b0100;
        wait_rsp(50, d, ns, nd, to);
        checks++; if (to || d !== 4'b0100) begin errors++; $display("FAIL single_done got %b want 0100", d); end
        checks++; if (rsp_result !== 32'd12) begin errors++; $display("FAIL single_result got %0d want 12", rsp_result); end
        checks++; if (grant_idx !== 2'd2) begin errors++; $display("FAIL single_grant got %0d want 2", grant_idx); end
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_starts got %0d want 1", start_cnt - s0); end
        checks++; if (nd - ns !== callee_lat + 3) begin errors++; $display("FAIL single_latency got %0d want %0d", nd - ns, callee_lat + 3); end
        req_valid[2] = 1'b0;
        @(negedge clk);
        checks++; if (rsp_done !== '0 || rsp_result !== 32'd12) begin errors++; $display("FAIL single_pulse got done=%b res=%0d want 0/12", rsp_done, rsp_result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", busy); end
        $display("test_single_call caller=2 result=%0d", rsp_result);
    endtask

    task automatic test_contention();
        int order[3] = '{0, 1, 3};
        logic [NC-1:0] d; int ns, nd; bit to;
        pulse_reset();
        for (int i = 0; i < NC; i++) begin
            req_a[i*W +: W] = 32'(i * 10 + 1);
            req_b[i*W +: W] = 32'(i + 2);
        end
        callee_lat = 2;
        req_valid = 4'b1011;
        foreach (order[k]) begin
            wait_rsp(60, d, ns, nd, to);
            checks++; if (to || d !== (4'b0001 << order[k])) begin errors++; $display("FAIL contention_done%0d got %b want %b", k, d, 4'b0001 << order[k]); end
            checks++; if (rsp_result !== 32'(order[k] * 11 + 3)) begin errors++; $display("FAIL contention_result%0d got %0d want %0d", k, rsp_result, order[k] * 11 + 3); end
            checks++; if (grant_idx !== 2'(order[k])) begin errors++; $display("FAIL contention_grant%0d got %0d want %0d", k, grant_idx, order[k]); end
            req_valid[order[k]] = 1'b0;
            @(negedge clk);
            checks++; if (rsp_done !== '0) begin errors++; $display("FAIL contention_pulse%0d got %b want 0", k, rsp_done); end
            $display("test_contention served caller=%0d result=%0d", order[k], rsp_result);
        end
    endtask

    task automatic test_wrap();
        int order[2] = '{0, 2};
        logic [NC-1:0] d; int ns, nd; bit to; int s0;
        s0 = start_cnt;
        req_valid = 4'b0101;
        foreach (order[k]) begin
            wait_rsp(60, d, ns, nd, to);
            checks++; if (to || d !== (4'b0001 << order[k])) begin errors++; $display("FAIL wrap_done%0d got %b want %b", k, d, 4'b0001 << order[k]); end
            checks++; if (rsp_result !== 32'(order[k] * 11 + 3)) begin errors++; $display("FAIL wrap_result%0d got %0d want %0d", k, rsp_result, order[k] * 11 + 3); end
            req_valid[order[k]] = 1'b0;
            @(negedge clk);
            $display("test_wrap served caller=%0d result=%0d", order[k], rsp_result);
        end
        checks++; if (start_cnt - s0 !== 2) begin errors++; $display("FAIL wrap_starts got %0d want 2", start_cnt - s0); end
    endtask

    task automatic test_operand_stability();
        logic [NC-1:0] d; int ns, nd; bit to;
        callee_lat = 6;
        req_a[1*W +: W] = 32'd100; req_b[1*W +: W] = 32'd1;
        req_valid = 4'b0010;
        for (int i = 0; i < 20 && callee_start !== 1'b1; i++) @(negedge clk);
        checks++; if (callee_start !== 1'b1) begin errors++; $display("FAIL stab_start got %b want 1", callee_start); end
        repeat (3) @(negedge clk);
        req_a[1*W +: W] = 32'd999;
        @(negedge clk);
        checks++; if (callee_a !== 32'd100) begin errors++; $display("FAIL stab_callee_a got %0d want 100", callee_a); end
        wait_rsp(60, d, ns, nd, to);
        checks++; if (to || d !== 4'b0010 || rsp_result !== 32'd101) begin errors++; $display("FAIL stab_result got %b/%0d want 0010/101", d, rsp_result); end
        req_valid[1] = 1'b0;
        @(negedge clk);
        $display("test_operand_stability result=%0d", rsp_result);
    endtask

    task automatic test_slow_callee();
        logic [NC-1:0] d; int ns, nd; bit to; int bad;
        callee_lat = 20;
        req_a[3*W +: W] = 32'd5; req_b[3*W +: W] = 32'd6;
        req_valid = 4'b1000;
        for (int i = 0; i < 20 && callee_start !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || rsp_done !== '0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL slow_wait got %0d bad cycles want 0", bad); end
        wait_rsp(10, d, ns, nd, to);
        checks++; if (to || d !== 4'b1000 || rsp_result !== 32'd11) begin errors++; $display("FAIL slow_result got %b/%0d want 1000/11", d, rsp_result); end
        req_valid[3] = 1'b0;
        @(negedge clk);
        $display("test_slow_callee result=%0d", rsp_result);
    endtask

    task automatic test_reset_mid();
        int order[2] = '{0, 1};
        logic [NC-1:0] d; int ns, nd; bit to;
        callee_lat = 10;
        req_a[1*W +: W] = 32'd3;  req_b[1*W +: W] = 32'd4;
        req_a[0*W +: W] = 32'd20; req_b[0*W +: W] = 32'd22;
        req_valid = 4'b0010;
        for (int i = 0; i < 20 && callee_start !== 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        req_valid[0] = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rsp_done !== '0 || callee_start !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got busy=%b done=%b start=%b want 0", busy, rsp_done, callee_start); end
        checks++; if (callee_a !== '0 || rsp_result !== '0 || grant_idx !== 2'd0) begin errors++; $display("FAIL midreset_data got a=%0d res=%0d grant=%0d want 0", callee_a, rsp_result, grant_idx); end
        @(negedge clk);
        reset = 1'b1;
        callee_lat = 2;
        foreach (order[k]) begin
            wait_rsp(60, d, ns, nd, to);
            checks++; if (to || d !== (4'b0001 << order[k])) begin errors++; $display("FAIL midreset_done%0d got %b want %b", k, d, 4'b0001 << order[k]); end
            req_valid[order[k]] = 1'b0;
            @(negedge clk);
            $display("test_reset_mid served caller=%0d result=%0d", order[k], rsp_result);
        end
    endtask

    task automatic test_random();
        logic [NC-1:0] pend, d;
        logic [W-1:0] a_op [NC];
        logic [W-1:0] b_op [NC];
        logic [W-1:0] exp_res;
        int last_m, w, served, ns, nd;
        bit to;
        pulse_reset();
        last_m = NC - 1;
        pend = 4'($urandom_range(1, 15));
        for (int i = 0; i < NC; i++) begin
            a_op[i] = $urandom; b_op[i] = $urandom;
            req_a[i*W +: W] = a_op[i]; req_b[i*W +: W] = b_op[i];
        end
        req_valid = pend;
        callee_lat = $urandom_range(1, 4);
        served = 0;
        while (pend != '0 && served < 60) begin
            w = rr_expect(pend, last_m);
            exp_res = a_op[w] + b_op[w];
            wait_rsp(80, d, ns, nd, to);
            checks++; if (to || d !== (4'b0001 << w)) begin errors++; $display("FAIL rand_done%0d got %b want %b", served, d, 4'b0001 << w); end
            checks++; if (rsp_result !== exp_res || start_a !== a_op[w] || grant_idx !== 2'(w)) begin errors++; $display("FAIL rand_data%0d got res=%0h a=%0h grant=%0d want %0h/%0h/%0d", served, rsp_result, start_a, grant_idx, exp_res, a_op[w], w); end
            $display("test_random call=%0d caller=%0d result=%0h", served, w, rsp_result);
            if (to) break;
            pend[w] = 1'b0; req_valid[w] = 1'b0; last_m = w; served++;
            if (served < 40) begin
                for (int i = 0; i < NC; i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        pend[i] = 1'b1;
                        a_op[i] = $urandom; b_op[i] = $urandom;
                        req_a[i*W +: W] = a_op[i]; req_b[i*W +: W] = b_op[i];
                        req_valid[i] = 1'b1;
                    end
                end
            end
            callee_lat = $urandom_range(1, 4);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_contention();
        test_wrap();
        test_operand_stability();
        test_slow_callee();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
